fir_engine: RTL and testbench

// Parametrised FIR engine: AXI-Lite config/status, AXI-Stream sample in/out, coefficients and sample history in external single-port BRAMs.

---
 rtl/fir_engine.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fir_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_engine.sv
// Runtime-configurable FIR engine: AXI-Lite control/status, AXI-Stream sample path,
// coefficients and sample history held in external single-port BRAMs (1-cycle read latency).
module fir_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pOUT_SHIFT  = 0
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);
  localparam int IW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam int CW = $clog2(Tape_Num + 3);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAPS = pADDR_WIDTH'('h14);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'('h80);
  localparam logic [CW-1:0]          TC_MAX    = CW'(Tape_Num);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a < pADDR_WIDTH'('h80 + 4 * Tape_Num));
  endfunction

  state_t                 state_q;
  logic                   start_q, done_q, err_q;
  logic [pDATA_WIDTH-1:0] len_q, tcnt_q, out_cnt_q;
  logic [CW-1:0]          tc_q, cnt_q;
  logic [IW-1:0]          ptr_q, idx_q;
  logic [pDATA_WIDTH-1:0] prod_q, acc_q, acc_d;
  logic                   ss_tready_q, sm_tvalid_q, sm_tlast_q;
  logic [pDATA_WIDTH-1:0] sm_tdata_q;

  logic                   awready_q, arready_q, rd_s1_q, rd_s2_q, rd_bram_q, rvalid_q;
  logic [pADDR_WIDTH-1:0] rd_addr_q;
  logic [pDATA_WIDTH-1:0] rd_val_q, rd_val_d, rdata_q;

  logic idle, aw_hs, ar_hs, in_hs, out_hs, is_last, rd_busy;
  logic [pADDR_WIDTH-1:0] aw_off, ar_off;

  assign idle    = (state_q == S_IDLE);
  assign aw_hs   = awvalid & wvalid & awready_q;
  assign ar_hs   = arvalid & arready_q;
  assign in_hs   = ss_tvalid & ss_tready_q;
  assign out_hs  = sm_tvalid_q & sm_tready;
  assign is_last = (out_cnt_q == len_q - 1'b1);
  assign rd_busy = rd_s1_q | rd_s2_q | rvalid_q;
  assign aw_off  = (awaddr - TAP_BASE) & ~pADDR_WIDTH'(3);
  assign ar_off  = (araddr - TAP_BASE) & ~pADDR_WIDTH'(3);
  assign acc_d   = acc_q + prod_q;

  assign awready   = awready_q;
  assign wready    = awready_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign ss_tready = ss_tready_q;
  assign sm_tvalid = sm_tvalid_q;
  assign sm_tdata  = sm_tdata_q;
  assign sm_tlast  = sm_tlast_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      tcnt_q      <= '0;
      out_cnt_q   <= '0;
      tc_q        <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      ss_tready_q <= 1'b0;
      sm_tvalid_q <= 1'b0;
      sm_tlast_q  <= 1'b0;
      sm_tdata_q  <= '0;
    end else begin
      start_q <= 1'b0;
      if (aw_hs && idle && awaddr == ADDR_CTRL && wdata[0]) begin
        start_q <= 1'b1;
        err_q   <= 1'b0;
      end
      if (aw_hs && idle && awaddr == ADDR_LEN)  len_q  <= wdata;
      if (aw_hs && idle && awaddr == ADDR_TAPS) tcnt_q <= wdata;
      if (ar_hs && araddr == ADDR_CTRL) done_q <= 1'b0;

      case (state_q)
        S_IDLE: if (start_q) begin
          state_q   <= S_CLEAR;
          cnt_q     <= '0;
          ptr_q     <= '0;
          out_cnt_q <= '0;
          done_q    <= 1'b0;
          tc_q      <= (tcnt_q == '0 || tcnt_q > pDATA_WIDTH'(Tape_Num)) ? TC_MAX : CW'(tcnt_q);
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == TC_MAX - 1'b1) begin
            cnt_q <= '0;
            if (len_q == '0) state_q <= S_DONE;
            else begin
              state_q     <= S_WAIT_IN;
              ss_tready_q <= 1'b1;
            end
          end
        end
        S_WAIT_IN: if (in_hs) begin
          ss_tready_q <= 1'b0;
          state_q     <= S_MAC;
          cnt_q       <= '0;
          idx_q       <= ptr_q;
          acc_q       <= '0;
          if (ss_tlast != is_last) err_q <= 1'b1;
        end
        // Three-stage pipe: address at cnt, BRAM data at cnt+1, product into acc at cnt+2.
        S_MAC: begin
          cnt_q <= cnt_q + 1'b1;
          idx_q <= (idx_q == '0) ? IW'(Tape_Num - 1) : idx_q - 1'b1;
          if (cnt_q >= CW'(1) && cnt_q <= tc_q) prod_q <= tap_Do * data_Do;
          if (cnt_q >= CW'(2)) acc_q <= acc_d;
          if (cnt_q == tc_q + 1'b1) begin
            state_q     <= S_OUT;
            sm_tvalid_q <= 1'b1;
            sm_tlast_q  <= is_last;
            sm_tdata_q  <= pDATA_WIDTH'($signed(acc_d) >>> pOUT_SHIFT);
          end
        end
        S_OUT: if (out_hs) begin
          sm_tvalid_q <= 1'b0;
          sm_tlast_q  <= 1'b0;
          out_cnt_q   <= out_cnt_q + 1'b1;
          ptr_q       <= (ptr_q == IW'(Tape_Num - 1)) ? '0 : ptr_q + 1'b1;
          if (is_last) state_q <= S_DONE;
          else begin
            state_q     <= S_WAIT_IN;
            ss_tready_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val_d = '0;
    if (is_tap(araddr))          rd_val_d = idle ? '0 : '1;
    else if (araddr == ADDR_CTRL) rd_val_d = pDATA_WIDTH'({err_q, idle, done_q, start_q});
    else if (araddr == ADDR_LEN)  rd_val_d = len_q;
    else if (araddr == ADDR_TAPS) rd_val_d = tcnt_q;
  end

  // Writes and tap reads are serialised so the tap port never sees both in one cycle.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      rd_s1_q   <= 1'b0;
      rd_s2_q   <= 1'b0;
      rd_bram_q <= 1'b0;
      rd_addr_q <= '0;
      rd_val_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= awvalid & wvalid & ~awready_q & ~rd_busy & ~ar_hs;
      arready_q <= arvalid & ~arready_q & ~rd_busy;
      rd_s1_q   <= ar_hs;
      rd_s2_q   <= rd_s1_q;
      if (ar_hs) begin
        rd_bram_q <= is_tap(araddr) & idle;
        rd_addr_q <= ar_off;
        rd_val_q  <= rd_val_d;
      end
      if (rd_s2_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_bram_q ? tap_Do : rd_val_q;
      end else if (rvalid_q && rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    tap_WE  = '0;
    tap_EN  = 1'b0;
    tap_Di  = '0;
    tap_A   = '0;
    data_WE = '0;
    data_EN = 1'b0;
    data_Di = '0;
    data_A  = '0;
    if (aw_hs && idle && is_tap(awaddr)) begin
      tap_WE = 4'hF;
      tap_EN = 1'b1;
      tap_Di = wdata;
      tap_A  = aw_off;
    end else if (rd_s1_q && rd_bram_q) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr_q;
    end else if (state_q == S_MAC && cnt_q < tc_q) begin
      tap_EN = 1'b1;
      tap_A  = pADDR_WIDTH'({cnt_q, 2'b00});
    end
    case (state_q)
      S_CLEAR: begin
        data_WE = 4'hF;
        data_EN = 1'b1;
        data_A  = pADDR_WIDTH'({cnt_q, 2'b00});
      end
      S_WAIT_IN: if (in_hs) begin
        data_WE = 4'hF;
        data_EN = 1'b1;
        data_Di = ss_tdata;
        data_A  = pADDR_WIDTH'({ptr_q, 2'b00});
      end
      S_MAC: if (cnt_q < tc_q) begin
        data_EN = 1'b1;
        data_A  = pADDR_WIDTH'({idx_q, 2'b00});
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fir_engine.sv
// Scoreboard bench for fir_engine: two instances (output shift 0 and 2) share stimulus and BRAMs;
// expected outputs come from a direct convolution over the sample history.
module tb_fir_engine;
  localparam int TN = 11;

  logic        clk, rst_n;
  logic        awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, sm_tready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, ss_tdata;
  logic        awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast;
  logic [31:0] rdata, sm_tdata;
  logic [3:0]  tap_WE, data_WE;
  logic        tap_EN, data_EN;
  logic [31:0] tap_Di, data_Di, tap_Do, data_Do;
  logic [11:0] tap_A, data_A;
  // second instance (pOUT_SHIFT=2); its BRAM requests mirror the first, so it shares the RAM models
  logic        awready1, wready1, arready1, rvalid1, ss_tready1, sm_tvalid1, sm_tlast1;
  logic [31:0] rdata1, sm_tdata1, tap_Di1, data_Di1;
  logic [3:0]  tap_WE1, data_WE1;
  logic        tap_EN1, data_EN1;
  logic [11:0] tap_A1, data_A1;

  fir_engine #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TN), .pOUT_SHIFT(0)) u_dut0 (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do));

  fir_engine #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TN), .pOUT_SHIFT(2)) u_dut1 (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready1), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready1), .wdata(wdata),
    .arvalid(arvalid), .arready(arready1), .araddr(araddr),
    .rvalid(rvalid1), .rready(rready), .rdata(rdata1),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready1),
    .sm_tvalid(sm_tvalid1), .sm_tdata(sm_tdata1), .sm_tlast(sm_tlast1), .sm_tready(sm_tready),
    .tap_WE(tap_WE1), .tap_EN(tap_EN1), .tap_Di(tap_Di1), .tap_A(tap_A1), .tap_Do(tap_Do),
    .data_WE(data_WE1), .data_EN(data_EN1), .data_Di(data_Di1), .data_A(data_A1), .data_Do(data_Do));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port BRAM models, 1-cycle read latency, byte write enables
  logic [31:0] tap_mem [0:TN-1];
  logic [31:0] data_mem[0:TN-1];
  always @(posedge clk) begin
    if (tap_EN) begin
      if (int'(tap_A[11:2]) < TN) begin
        tap_Do <= tap_mem[tap_A[11:2]];
        for (int b = 0; b < 4; b++) if (tap_WE[b]) tap_mem[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      end else tap_Do <= '0;
    end
    if (data_EN) begin
      if (int'(data_A[11:2]) < TN) begin
        data_Do <= data_mem[data_A[11:2]];
        for (int b = 0; b < 4; b++) if (data_WE[b]) data_mem[data_A[11:2]][8*b +: 8] <= data_Di[8*b +: 8];
      end else data_Do <= '0;
    end
  end

  int vectors = 0, miscompares = 0;
  typedef struct { logic [31:0] acc; logic last; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] tap_m[0:TN-1];
  logic [31:0] model_hist[$];
  logic [31:0] samp[$];
  logic        tl[$];
  int          tc_eff, len_m, bp_mode;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL timeout %s: got no handshake, required one within budget", name);
  endtask

  // output monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sm_tvalid && sm_tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sm_unexpected: got %h expected no output", sm_tdata);
        end else begin
          e = exp_q.pop_front();
          check("sm_tdata_sh0", sm_tdata, e.acc);
          check("sm_tdata_sh2", sm_tdata1, 32'($signed(e.acc) >>> 2));
          check("sm_tlast", {31'b0, sm_tlast}, {31'b0, e.last});
          check("sm_tvalid_sh2", {31'b0, sm_tvalid1}, 32'd1);
        end
      end
    end
  end

  initial begin
    int cyc = 0;
    sm_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (bp_mode)
        0:       sm_tready = 1'b1;
        1:       sm_tready = (cyc % 3 == 0);
        2:       sm_tready = 1'($urandom_range(1, 0));
        default: sm_tready = 1'b0;
      endcase
    end
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) timeout_fail("axi_write");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) timeout_fail("axi_arready");
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    if (!rvalid) timeout_fail("axi_rvalid");
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic load_taps(input int n);
    for (int k = 0; k < n; k++) axi_write(12'(32'h80 + 4 * k), tap_m[k]);
  endtask

  task automatic start_job(input logic [31:0] tc, input logic [31:0] len);
    axi_write(12'h14, tc);
    axi_write(12'h10, len);
    model_hist.delete();
    tc_eff = (tc == 0 || tc > TN) ? TN : int'(tc);
    len_m  = int'(len);
    axi_write(12'h00, 32'h1);
  endtask

  task automatic send_sample(input logic [31:0] d, input logic last, input int gap, input int idx);
    logic [31:0] acc = '0;
    int n = 0;
    model_hist.push_front(d);
    if (model_hist.size() > TN) void'(model_hist.pop_back());
    for (int k = 0; k < tc_eff && k < model_hist.size(); k++) acc = acc + tap_m[k] * model_hist[k];
    exp_q.push_back('{acc, idx == len_m - 1});
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    ss_tdata = d; ss_tlast = last; ss_tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!ss_tready && n < 2000);
    if (!ss_tready) timeout_fail("ss_tready");
    @(posedge clk); #1;
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
  endtask

  task automatic feed(input int gap_max, input logic midrun);
    logic [31:0] v;
    for (int i = 0; i < samp.size(); i++) begin
      send_sample(samp[i], tl[i], $urandom_range(gap_max, 0), i);
      if (midrun && i == 0) begin
        axi_write(12'h80, 32'd99);
        axi_write(12'h10, 32'd77);
        axi_read(12'h80, v);
        check("tap_read_busy", v, 32'hFFFF_FFFF);
      end
    end
  endtask

  task automatic finish_job(input logic [31:0] exp_ctrl);
    logic [31:0] v;
    int n = 0;
    do begin axi_read(12'h00, v); n++; end while (!v[1] && n < 400);
    if (!v[1]) timeout_fail("ap_done");
    else check("ap_ctrl_done", v, exp_ctrl);
    axi_read(12'h00, v);
    check("ap_ctrl_cleared", v, exp_ctrl & ~32'h2);
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  task automatic basic_samples(input logic [3:0] last_mask);
    samp = '{32'd1, 32'd2, 32'd3, 32'd4};
    tl.delete();
    for (int i = 0; i < 4; i++) tl.push_back(last_mask[i]);
  endtask

  initial begin
    logic [31:0] v;
    int n;
    rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0;
    ss_tvalid = 0; ss_tlast = 0; ss_tdata = '0; bp_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    check("rst_ss_tready", {31'b0, ss_tready}, 32'd0);
    check("rst_handshakes", {28'b0, awready, wready, arready, rvalid}, 32'd0);
    check("rst_bram_en", {30'b0, tap_EN, data_EN}, 32'd0);
    check("rst_sm_tdata", sm_tdata, 32'd0);
    rst_n = 1'b1;
    axi_read(12'h00, v);
    check("rst_ap_ctrl", v, 32'h4);

    // configuration and readback
    for (int k = 0; k < TN; k++) tap_m[k] = '0;
    tap_m[0] = 1; tap_m[1] = 2; tap_m[2] = 3;
    load_taps(3);
    axi_write(12'h14, 32'd3);
    axi_write(12'h10, 32'd4);
    axi_write(12'h24, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      axi_read(12'(32'h80 + 4 * k), v);
      check("tap_readback", v, tap_m[k]);
    end
    axi_read(12'h10, v); check("len_readback", v, 32'd4);
    axi_read(12'h14, v); check("tapcnt_readback", v, 32'd3);
    axi_read(12'h24, v); check("unmapped_read", v, 32'd0);

    // basic run with busy-time config writes that must be ignored
    basic_samples(4'b1000);
    start_job(3, 4);
    feed(0, 1'b1);
    finish_job(32'h6);
    axi_read(12'h80, v); check("tap0_unchanged", v, 32'd1);
    axi_read(12'h10, v); check("len_unchanged", v, 32'd4);

    // backpressure and gapped input
    bp_mode = 1;
    start_job(3, 4);
    feed(3, 1'b0);
    finish_job(32'h6);

    // tlast mismatch, then an empty job clears the sticky flag
    bp_mode = 0;
    basic_samples(4'b1010);
    start_job(3, 4);
    feed(0, 1'b0);
    finish_job(32'hE);
    start_job(3, 0);
    repeat (30) @(posedge clk);
    finish_job(32'h6);

    // full depth with wrap, randomized samples and backpressure
    tap_m = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};
    load_taps(TN);
    bp_mode = 2;
    samp.delete(); tl.delete();
    for (int i = 0; i < 600; i++) begin
      samp.push_back($urandom);
      tl.push_back(i == 599);
    end
    start_job(TN, 600);
    feed(2, 1'b0);
    finish_job(32'h6);

    // tap_count clamping (0 and above the maximum) with random coefficients
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < TN; k++) tap_m[k] = $urandom;
      load_taps(TN);
      samp.delete(); tl.delete();
      for (int i = 0; i < 25; i++) begin
        samp.push_back($urandom);
        tl.push_back(i == 24);
      end
      start_job(r == 0 ? 32'd0 : 32'd20, 25);
      feed(1, 1'b0);
      finish_job(32'h6);
    end

    // asynchronous reset while an output is being held
    tap_m[0] = 1; tap_m[1] = 2; tap_m[2] = 3;
    load_taps(3);
    bp_mode = 3;
    basic_samples(4'b1000);
    start_job(3, 4);
    send_sample(samp[0], 1'b0, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!sm_tvalid && n < 100);
    if (!sm_tvalid) timeout_fail("sm_tvalid_before_reset");
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    check("midrst_ss_tready", {31'b0, ss_tready}, 32'd0);
    check("midrst_bram_we", {24'b0, tap_WE, data_WE}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_bram_we_held", {24'b0, tap_WE, data_WE}, 32'd0);
    rst_n = 1'b1;
    bp_mode = 0;
    axi_read(12'h00, v); check("midrst_ap_ctrl", v, 32'h4);
    axi_read(12'h10, v); check("midrst_len", v, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, required finish within budget");
    $fatal(1, "watchdog expired");
  end
endmodule
